paritysel_mux_arbiter: RTL and testbench

//   Two-requester round-robin arbiter/sequencer for the parity-select mux.

---
 rtl/paritysel_mux_arbiter.sv | 172 +++++++++++++++++
 tb/tb_paritysel_mux_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/paritysel_mux_arbiter.sv
// ---------------------------------------------------------------------------
// paritysel_mux_arbiter
//   Two-requester round-robin arbiter/sequencer for the parity-select mux.
//   An internal 4-bit sel register drives the mux: an even sel picks source A
//   and an odd sel picks source B. sel also serves as a rolling transfer tag.
//   The winning word is registered into a single-entry output stage with a
//   valid/ready handshake.
//
// Optional feature macro: PARITYSEL_ARB_STATS_EN
//   When defined, adds saturating per-source grant counters on two extra ports.
//
// Ports
//   clk          in   1      single clock, rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   a_valid      in   1      source A word available
//   a_ready      out  1      A word accepted this cycle (combinational)
//   a_data       in   WIDTH  source A data
//   b_valid      in   1      source B word available
//   b_ready      out  1      B word accepted this cycle (combinational)
//   b_data       in   WIDTH  source B data
//   out_valid    out  1      output stage holds a word
//   out_ready    in   1      downstream accepts the output word
//   out_data     out  WIDTH  registered mux output
//   out_sel      out  4      sel value used to produce out_data
//   grant_cnt_a  out  8      (stats build only) granted A words, saturating
//   grant_cnt_b  out  8      (stats build only) granted B words, saturating
// ---------------------------------------------------------------------------
module paritysel_mux_arbiter #(
    parameter  int WIDTH   = 8,
    localparam int T_WIDTH = WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [T_WIDTH:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [T_WIDTH:0] b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [T_WIDTH:0] out_data,
`ifdef PARITYSEL_ARB_STATS_EN
    output logic [7:0]       grant_cnt_a,
    output logic [7:0]       grant_cnt_b,
`endif
    output logic [3:0]       out_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       sel;
    logic [3:0]       sel_next;
    logic             load_en;
    logic             pref_b;
    logic             grant_a;
    logic             grant_b;
    logic             grant_any;
    logic [T_WIDTH:0] mux_data;

    assign out_valid = (state == FULL);

    // Round-robin arbitration. The stage can take a word when it is empty or
    // is being drained this very cycle. The preferred source is the one
    // opposite to the parity of the last grant; the other source only wins
    // when the preferred one is idle. Holding reset forces both readies low.
    always_comb begin
        load_en = (state == EMPTY) || out_ready;
        pref_b  = ~sel[0];
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (load_en && rst_n) begin
            if (pref_b) begin
                if (b_valid) begin
                    grant_b = 1'b1;
                end else if (a_valid) begin
                    grant_a = 1'b1;
                end
            end else begin
                if (a_valid) begin
                    grant_a = 1'b1;
                end else if (b_valid) begin
                    grant_b = 1'b1;
                end
            end
        end
    end

    assign grant_any = grant_a | grant_b;
    assign a_ready   = grant_a;
    assign b_ready   = grant_b;

    // Next sel value. A grant that flips parity steps by one; a grant that
    // keeps parity steps by two so the low bit still names the source. The
    // result wraps mod 16 and directly steers the mux for the loaded word.
    always_comb begin
        sel_next = sel;
        if (grant_any) begin
            if (grant_b != sel[0]) begin
                sel_next = sel + 4'd1;
            end else begin
                sel_next = sel + 4'd2;
            end
        end
        mux_data = sel_next[0] ? b_data : a_data;
    end

    // Output stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Output stage next-state logic. A grant while draining reloads the stage
    // in the same edge, so a continuous stream never sees a bubble.
    always_comb begin
        state_next = state;
        case (state)
            EMPTY: begin
                if (grant_any) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_ready && !grant_any) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Datapath registers. Only a grant changes them; when the stage empties
    // out_data and out_sel deliberately keep their stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= 4'h0;
            out_sel  <= 4'h0;
            out_data <= '0;
        end else if (grant_any) begin
            sel      <= sel_next;
            out_sel  <= sel_next;
            out_data <= mux_data;
        end
    end

`ifdef PARITYSEL_ARB_STATS_EN
    // Per-source grant counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_a <= 8'h00;
            grant_cnt_b <= 8'h00;
        end else begin
            if (grant_a && (grant_cnt_a != 8'hFF)) begin
                grant_cnt_a <= grant_cnt_a + 8'd1;
            end
            if (grant_b && (grant_cnt_b != 8'hFF)) begin
                grant_cnt_b <= grant_cnt_b + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_paritysel_mux_arbiter.sv
// ---------------------------------------------------------------------------
// tb_paritysel_mux_arbiter
//   Directed stimulus for paritysel_mux_arbiter. The driver pushes the
//   hand-computed word/tag expected for every grant into a queue; a monitor
//   pops and compares whenever the output stage hands a word downstream.
//   Build with PARITYSEL_ARB_STATS_EN defined to also exercise the counters.
// ---------------------------------------------------------------------------
module tb_paritysel_mux_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] sel;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] a_data;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] b_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] out_sel;
`ifdef PARITYSEL_ARB_STATS_EN
    logic [7:0] grant_cnt_a;
    logic [7:0] grant_cnt_b;
`endif

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    paritysel_mux_arbiter #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_data     (b_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef PARITYSEL_ARB_STATS_EN
        .grant_cnt_a(grant_cnt_a),
        .grant_cnt_b(grant_cnt_b),
`endif
        .out_sel    (out_sel)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive just after the edge, check the
    // combinational readies mid-cycle, and queue the expected word on a grant.
    task automatic applyStimulus(input logic av, input logic [7:0] ad,
                                 input logic bv, input logic [7:0] bd,
                                 input logic ordy, input logic exp_ar,
                                 input logic exp_br, input logic [3:0] exp_sel);
        exp_t e;
        @(posedge clk);
        #1;
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        out_ready = ordy;
        #2;
        checkOutput("a_ready", 32'(a_ready), 32'(exp_ar));
        checkOutput("b_ready", 32'(b_ready), 32'(exp_br));
        if (exp_ar || exp_br) begin
            e.data = exp_ar ? ad : bd;
            e.sel  = exp_sel;
            exp_q.push_back(e);
        end
    endtask

    // Reset pulse between edges; anything queued is dropped with the DUT word.
    task automatic doReset();
        @(posedge clk);
        #1;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sel", 32'(out_sel), 32'd0);
        rst_n = 1'b1;
    endtask

    // Monitor: every accepted output word must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_word: got data %0h sel %0h expected none", out_data, out_sel);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", 32'(out_data), 32'(e.data));
                    checkOutput("out_sel", 32'(out_sel), 32'(e.sel));
                end
            end
        end
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] t4_sel [9];
        logic [3:0] s;
        t4_sel = '{4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF, 4'h1, 4'h3};

        // Reset state, with A requesting to prove ready stays low in reset.
        rst_n     = 1'b0;
        a_valid   = 1'b1;
        a_data    = 8'h5A;
        b_valid   = 1'b1;
        b_data    = 8'hA5;
        out_ready = 1'b1;
        #3;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_data", 32'(out_data), 32'd0);
        checkOutput("reset_out_sel", 32'(out_sel), 32'd0);
        checkOutput("reset_a_ready", 32'(a_ready), 32'd0);
        checkOutput("reset_b_ready", 32'(b_ready), 32'd0);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b1;

        // Single A word from reset: parity kept, so sel steps 0 -> 2.
        applyStimulus(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'h2);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("t1_out_valid", 32'(out_valid), 32'd1);

        // Contention from reset: B first, then strict alternation, tags 1..4.
        doReset();
        for (int i = 0; i < 4; i++) begin
            if ((i % 2) == 0) begin
                applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1, 1'b0, 1'b1, 4'(i + 1));
            end else begin
                applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b1, 8'hB0 + 8'(i), 1'b1, 1'b1, 1'b0, 4'(i + 1));
            end
        end

        // Back-pressure: stage holds A3/tag 4, nobody is granted.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'hC0, 1'b1, 8'hD0, 1'b0, 1'b0, 1'b0, 4'h0);
            checkOutput("t3_hold_valid", 32'(out_valid), 32'd1);
            checkOutput("t3_hold_data", 32'(out_data), 32'hA3);
            checkOutput("t3_hold_sel", 32'(out_sel), 32'h4);
        end
        // Release: B granted in the same cycle the held word drains.
        applyStimulus(1'b1, 8'hC1, 1'b1, 8'hD1, 1'b1, 1'b0, 1'b1, 4'h5);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);

        // B only: reach sel=1, then nine more grants wrapping through F.
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 4'h1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 8'h41 + 8'(i), 1'b1, 1'b0, 1'b1, t4_sel[i]);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);

        // Fill the stage (sel 3 -> 4), stall it, then reset asynchronously.
        applyStimulus(1'b1, 8'h77, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'h4);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("t5_full", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_async_sel", 32'(out_sel), 32'd0);
        checkOutput("t5_async_data", 32'(out_data), 32'd0);
        checkOutput("t5_async_a_ready", 32'(a_ready), 32'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h81, 1'b1, 8'h91, 1'b1, 1'b0, 1'b1, 4'h1);
        applyStimulus(1'b1, 8'h82, 1'b1, 8'h92, 1'b1, 1'b1, 1'b0, 4'h2);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);

`ifdef PARITYSEL_ARB_STATS_EN
        // 300 A-only grants: counter A saturates, counter B stays zero.
        doReset();
        for (int i = 0; i < 300; i++) begin
            s = 4'(2 * (i + 1));
            applyStimulus(1'b1, 8'(i), 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, s);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'h0);
        checkOutput("grant_cnt_a", 32'(grant_cnt_a), 32'hFF);
        checkOutput("grant_cnt_b", 32'(grant_cnt_b), 32'h00);
`else
        s = 4'h0;
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
